// File: rtl/sram_test_ctrl.sv
// sram_test_ctrl: drives two SRAM macros from Wishbone or a pin scan chain.
// Define SRAM_CMP_EN to add the EXP compare register and sticky err flags.
module sram_test_ctrl #(
   parameter logic [31:0] BASE_ADR = 32'h3000_0000,
   parameter int          ADDR_W   = 8,
   parameter int          DATA_W   = 32
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [1:0]        in_select,
   input  logic              gpio_clk,
   input  logic              gpio_in,
   input  logic              gpio_scan,
   input  logic              gpio_sram_load,
   input  logic              global_csb,
   output logic              gpio_out,
   input  logic              wbs_stb_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
`ifdef SRAM_CMP_EN
   output logic [1:0]        err,
`endif
   output logic [1:0]        sram_csb,
   output logic              sram_web,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout0,
   input  logic [DATA_W-1:0] sram_dout1
);

   localparam int PKT_W = ADDR_W + DATA_W + 2;

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;
   state_t state, state_n;

   logic [4:0]        sync_a, sync_b;
   logic              clk_q, load_q;
   logic              s_clk, s_in, s_scan, s_load, s_gcsb;
   logic              clk_rise, load_rise;
   logic [ADDR_W-1:0] ctrl_addr, op_addr;
   logic              ctrl_web, ctrl_sel;
   logic              op_web, op_sel, op_scan;
   logic [DATA_W-1:0] wdata, rdata, op_din, rd_word;
   logic [PKT_W-1:0]  pkt;
   logic              wb_hit, wb_wr;
   logic [1:0]        wb_off;
   logic [31:0]       ctrl_word, rd_mux;
   logic              wb_start, scan_start;
   logic              start, busy, cap;
   logic              unused_ok;

   assign {s_gcsb, s_load, s_scan, s_in, s_clk} = sync_b;
   assign clk_rise  = s_clk & ~clk_q;
   assign load_rise = s_load & ~load_q;
   assign gpio_out  = pkt[PKT_W-1];

   // ack gating keeps a held strobe from being acked twice in a row
   assign wb_hit = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o
                 & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
   assign wb_wr  = wb_hit & wbs_we_i;
   assign wb_off = wbs_adr_i[3:2];

   assign wb_start   = wb_wr & (wb_off == 2'd3)
                     & wbs_dat_i[0] & (in_select == 2'b10);
   assign scan_start = load_rise & ~s_gcsb
                     & (in_select == 2'b00);

   assign rd_word   = op_sel ? sram_dout1 : sram_dout0;
   assign cap       = (state == CAPTURE) & op_web;
   assign sram_addr = op_addr;
   assign sram_din  = op_din;
   assign unused_ok = &{1'b0, wbs_sel_i, wbs_adr_i[1:0]};

   always_comb begin
      ctrl_word             = '0;
      ctrl_word[ADDR_W-1:0] = ctrl_addr;
      ctrl_word[16]         = ctrl_web;
      ctrl_word[24]         = ctrl_sel;
   end

   always_comb begin
      rd_mux = '0;
      unique case (wb_off)
         2'd0: rd_mux = ctrl_word;
         2'd1: rd_mux = wdata;
         2'd2: rd_mux = rdata;
         2'd3: rd_mux = {31'b0, busy};
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n  = state;
      start    = 1'b0;
      busy     = 1'b0;
      sram_csb = 2'b11;
      sram_web = 1'b1;
      unique case (state)
         IDLE: begin
            if (wb_start | scan_start) begin
               start   = 1'b1;
               state_n = ACCESS;
            end
         end
         ACCESS: begin
            busy             = 1'b1;
            sram_csb[op_sel] = 1'b0;
            sram_web         = op_web;
            state_n          = CAPTURE;
         end
         CAPTURE: begin
            busy    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync_a <= '0;
         sync_b <= '0;
         clk_q  <= 1'b0;
         load_q <= 1'b0;
      end else begin
         sync_a <= {global_csb, gpio_sram_load,
                    gpio_scan, gpio_in, gpio_clk};
         sync_b <= sync_a;
         clk_q  <= s_clk;
         load_q <= s_load;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         ctrl_addr <= '0;
         ctrl_web  <= 1'b0;
         ctrl_sel  <= 1'b0;
         wdata     <= '0;
      end else begin
         wbs_ack_o <= wb_hit;
         if (wb_hit & ~wbs_we_i) wbs_dat_o <= rd_mux;
         if (wb_wr & (wb_off == 2'd0)) begin
            ctrl_addr <= wbs_dat_i[ADDR_W-1:0];
            ctrl_web  <= wbs_dat_i[16];
            ctrl_sel  <= wbs_dat_i[24];
         end
         if (wb_wr & (wb_off == 2'd1)) wdata <= wbs_dat_i;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         op_addr <= '0;
         op_din  <= '0;
         op_web  <= 1'b0;
         op_sel  <= 1'b0;
         op_scan <= 1'b0;
         rdata   <= '0;
      end else begin
         if (start) begin
            op_scan <= scan_start;
            if (scan_start) begin
               op_sel  <= pkt[PKT_W-1];
               op_web  <= pkt[PKT_W-2];
               op_addr <= pkt[DATA_W +: ADDR_W];
               op_din  <= pkt[DATA_W-1:0];
            end else begin
               op_sel  <= ctrl_sel;
               op_web  <= ctrl_web;
               op_addr <= ctrl_addr;
               op_din  <= wdata;
            end
         end
         if (cap) rdata <= rd_word;
      end
   end

   // a scan-path read result takes priority over a coincident shift
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         pkt <= '0;
      else if (cap & op_scan)
         pkt[DATA_W-1:0] <= rd_word;
      else if (clk_rise & s_scan)
         pkt <= {pkt[PKT_W-2:0], s_in};
   end

`ifdef SRAM_CMP_EN
   logic [DATA_W-1:0] exp_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         exp_q <= '0;
         err   <= 2'b00;
      end else begin
         if (wb_wr & (wb_off == 2'd2)) exp_q <= wbs_dat_i;
         if (wb_wr & (wb_off == 2'd3) & wbs_dat_i[1])
            err <= 2'b00;
         if (cap & (rd_word != exp_q)) err[op_sel] <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sram_test_ctrl.sv
// tb_sram_test_ctrl: vector table, directed sequences and random ops
// against a memory scoreboard for sram_test_ctrl.
`timescale 1ns/1ps
module tb_sram_test_ctrl;

   localparam logic [31:0] A_CTRL  = 32'h3000_0000;
   localparam logic [31:0] A_WDATA = 32'h3000_0004;
   localparam logic [31:0] A_RDATA = 32'h3000_0008;
   localparam logic [31:0] A_CMD   = 32'h3000_000C;

   logic        clock = 1'b0;
   logic        resetn;
   logic [1:0]  in_select;
   logic        gpio_clk, gpio_in, gpio_scan;
   logic        gpio_sram_load, global_csb, gpio_out;
   logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
   logic        wbs_ack_o;
   logic [1:0]  sram_csb;
   logic        sram_web;
   logic [7:0]  sram_addr;
   logic [31:0] sram_din;
   logic [31:0] sram_dout0 = '0;
   logic [31:0] sram_dout1 = '0;
`ifdef SRAM_CMP_EN
   logic [1:0]  err;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem0 [256];
   logic [31:0] mem1 [256];
   logic [31:0] ref_mem [2][256];
   logic        bd_we = 1'b0;
   logic        bd_sel;
   logic [7:0]  bd_addr;
   logic [31:0] bd_dat;

   int          acc_cnt = 0;
   logic [1:0]  m_csb;
   logic        m_web;
   logic [7:0]  m_addr;
   logic [31:0] m_din;

   always #5 clock = ~clock;

   sram_test_ctrl dut (
      .clock          (clock),
      .resetn         (resetn),
      .in_select      (in_select),
      .gpio_clk       (gpio_clk),
      .gpio_in        (gpio_in),
      .gpio_scan      (gpio_scan),
      .gpio_sram_load (gpio_sram_load),
      .global_csb     (global_csb),
      .gpio_out       (gpio_out),
      .wbs_stb_i      (wbs_stb_i),
      .wbs_cyc_i      (wbs_cyc_i),
      .wbs_we_i       (wbs_we_i),
      .wbs_sel_i      (wbs_sel_i),
      .wbs_adr_i      (wbs_adr_i),
      .wbs_dat_i      (wbs_dat_i),
      .wbs_ack_o      (wbs_ack_o),
      .wbs_dat_o      (wbs_dat_o),
`ifdef SRAM_CMP_EN
      .err            (err),
`endif
      .sram_csb       (sram_csb),
      .sram_web       (sram_web),
      .sram_addr      (sram_addr),
      .sram_din       (sram_din),
      .sram_dout0     (sram_dout0),
      .sram_dout1     (sram_dout1)
   );

   // synchronous SRAM macro models with a backdoor preload port
   always @(posedge clock) begin
      if (bd_we && !bd_sel) mem0[bd_addr] <= bd_dat;
      if (bd_we &&  bd_sel) mem1[bd_addr] <= bd_dat;
      if (!sram_csb[0]) begin
         if (!sram_web) mem0[sram_addr] <= sram_din;
         else           sram_dout0 <= mem0[sram_addr];
      end
      if (!sram_csb[1]) begin
         if (!sram_web) mem1[sram_addr] <= sram_din;
         else           sram_dout1 <= mem1[sram_addr];
      end
   end

   always @(negedge clock) begin
      if (resetn && sram_csb != 2'b11) begin
         acc_cnt = acc_cnt + 1;
         m_csb   = sram_csb;
         m_web   = sram_web;
         m_addr  = sram_addr;
         m_din   = sram_din;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic preload(input logic s, input logic [7:0] a,
                          input logic [31:0] d);
      bd_we = 1'b1; bd_sel = s; bd_addr = a; bd_dat = d;
      tick(1);
      bd_we = 1'b0;
      ref_mem[s][a] = d;
   endtask

   task automatic wb_xfer(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat,
                          output logic [31:0] rd, output logic acked);
      wbs_adr_i = adr; wbs_dat_i = dat; wbs_we_i = we;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
      acked = 1'b0; rd = '0;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         if (wbs_ack_o) begin
            acked = 1'b1;
            rd = wbs_dat_o;
            break;
         end
      end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
      logic [31:0] rd;
      logic        ak;
      wb_xfer(1'b1, adr, dat, rd, ak);
      chk("wr_ack", {63'b0, ak}, 64'd1);
   endtask

   task automatic rdw(input logic [31:0] adr, output logic [31:0] rd);
      logic ak;
      wb_xfer(1'b0, adr, 32'h0, rd, ak);
      chk("rd_ack", {63'b0, ak}, 64'd1);
   endtask

   task automatic scan_bit(input logic b);
      gpio_in = b;
      tick(4);
      gpio_clk = 1'b1;
      tick(4);
      gpio_clk = 1'b0;
      tick(4);
   endtask

   task automatic scan_in(input logic [41:0] p);
      gpio_scan = 1'b1;
      for (int i = 41; i >= 0; i--) scan_bit(p[i]);
   endtask

   task automatic load_pulse();
      gpio_sram_load = 1'b1;
      tick(4);
      gpio_sram_load = 1'b0;
      tick(10);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic        ack;
      logic [31:0] rd;
   } vec_t;

   vec_t        tbl [12];
   logic [31:0] v;
   logic        ak;
   logic [41:0] got;
   int          c0;
   logic        r_sel, r_web;
   logic [7:0]  r_a;
   logic [31:0] r_d;

   initial begin
      tbl[0]  = '{1'b1, A_CTRL,  32'h0101_00A5, 1'b1, 32'h0};
      tbl[1]  = '{1'b0, A_CTRL,  32'h0,         1'b1, 32'h0101_00A5};
      tbl[2]  = '{1'b1, A_CTRL,  32'hFFFF_FFFF, 1'b1, 32'h0};
      tbl[3]  = '{1'b0, A_CTRL,  32'h0,         1'b1, 32'h0101_00FF};
      tbl[4]  = '{1'b1, A_WDATA, 32'h1234_5678, 1'b1, 32'h0};
      tbl[5]  = '{1'b0, 32'h3000_0006, 32'h0,   1'b1, 32'h1234_5678};
      tbl[6]  = '{1'b1, A_RDATA, 32'hFFFF_FFFF, 1'b1, 32'h0};
      tbl[7]  = '{1'b0, A_RDATA, 32'h0,         1'b1, 32'h0};
      tbl[8]  = '{1'b1, A_CMD,   32'h0,         1'b1, 32'h0};
      tbl[9]  = '{1'b0, A_CMD,   32'h0,         1'b1, 32'h0};
      tbl[10] = '{1'b1, 32'h3000_0010, 32'h1,   1'b0, 32'h0};
      tbl[11] = '{1'b0, 32'h2FFF_FFF0, 32'h0,   1'b0, 32'h0};

      resetn = 1'b0; in_select = 2'b10;
      gpio_clk = 0; gpio_in = 0; gpio_scan = 0;
      gpio_sram_load = 0; global_csb = 0;
      wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
      wbs_sel_i = 4'hF; wbs_adr_i = '0; wbs_dat_i = '0;

      for (int i = 0; i < 16; i++) begin
         preload(1'b0, 8'(i), $urandom);
         preload(1'b1, 8'(i), $urandom);
      end
      preload(1'b0, 8'd3, 32'h1234_5678);
      preload(1'b1, 8'd5, 32'hCAFE_F00D);
      preload(1'b0, 8'd9, 32'h0000_0002);

      chk("rst_csb",  {62'b0, sram_csb}, 64'h3);
      chk("rst_web",  {63'b0, sram_web}, 64'h1);
      chk("rst_addr", {56'b0, sram_addr}, 64'h0);
      chk("rst_din",  {32'b0, sram_din}, 64'h0);
      chk("rst_ack",  {63'b0, wbs_ack_o}, 64'h0);
      chk("rst_dat",  {32'b0, wbs_dat_o}, 64'h0);
      chk("rst_gout", {63'b0, gpio_out}, 64'h0);
      @(negedge clock);
      resetn = 1'b1;
      tick(2);

      wr(A_CTRL, 32'h0001_0007);
      wr(A_CMD, 32'h1);
      chk("mid_csb_low", {62'b0, sram_csb}, 64'h2);
      resetn = 1'b0;
      #1;
      chk("mid_rst_csb", {62'b0, sram_csb}, 64'h3);
      chk("mid_rst_ack", {63'b0, wbs_ack_o}, 64'h0);
      @(negedge clock);
      resetn = 1'b1;
      tick(2);
      rdw(A_CMD, v);
      chk("mid_busy", {32'b0, v}, 64'h0);

      for (int i = 0; i < 12; i++) begin
         wb_xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, v, ak);
         chk($sformatf("tbl%0d_ack", i), {63'b0, ak},
             {63'b0, tbl[i].ack});
         if (!tbl[i].we && tbl[i].ack)
            chk($sformatf("tbl%0d_dat", i), {32'b0, v},
                {32'b0, tbl[i].rd});
      end

      wr(A_CTRL, 32'h0000_0005);
      wr(A_WDATA, 32'hDEAD_BEEF);
      c0 = acc_cnt;
      wr(A_CMD, 32'h1);
      tick(4);
      ref_mem[0][5] = 32'hDEAD_BEEF;
      chk("w_cnt", 64'(acc_cnt - c0), 64'd1);
      chk("w_acc", {m_csb, m_web, m_addr, m_din},
          {2'b10, 1'b0, 8'd5, 32'hDEAD_BEEF});

      wr(A_CTRL, 32'h0101_0005);
      c0 = acc_cnt;
      wr(A_CMD, 32'h1);
      rdw(A_CMD, v);
      chk("r_busy", {32'b0, v}, 64'h1);
      rdw(A_CMD, v);
      chk("r_idle", {32'b0, v}, 64'h0);
      rdw(A_RDATA, v);
      chk("r_data", {32'b0, v}, {32'b0, ref_mem[1][5]});
      chk("r_acc", {m_csb, m_web, m_addr},
          {2'b01, 1'b1, 8'd5});

      c0 = acc_cnt;
      wr(A_CMD, 32'h1);
      wr(A_CMD, 32'h1);
      tick(6);
      chk("b2b_cnt", 64'(acc_cnt - c0), 64'd1);

      in_select = 2'b00;
      c0 = acc_cnt;
      wr(A_CMD, 32'h1);
      tick(6);
      chk("sel00_wb", 64'(acc_cnt - c0), 64'd0);

      in_select = 2'b10;
      scan_in({1'b0, 1'b1, 8'h03, 32'h0});
      c0 = acc_cnt;
      load_pulse();
      chk("sel10_scan", 64'(acc_cnt - c0), 64'd0);

      in_select = 2'b00;
      c0 = acc_cnt;
      load_pulse();
      chk("scan_cnt", 64'(acc_cnt - c0), 64'd1);
      chk("scan_acc", {m_csb, m_web, m_addr},
          {2'b10, 1'b1, 8'd3});
      rdw(A_RDATA, v);
      chk("scan_rdata", {32'b0, v}, {32'b0, ref_mem[0][3]});
      for (int i = 41; i >= 0; i--) begin
         got[i] = gpio_out;
         scan_bit(1'b0);
      end
      chk("scan_out", {22'b0, got},
          {22'b0, 1'b0, 1'b1, 8'h03, 32'h1234_5678});

      global_csb = 1'b1;
      tick(4);
      scan_in({1'b0, 1'b1, 8'h03, 32'h0});
      c0 = acc_cnt;
      load_pulse();
      chk("gcsb_block", 64'(acc_cnt - c0), 64'd0);
      global_csb = 1'b0;

`ifdef SRAM_CMP_EN
      in_select = 2'b10;
      chk("err_init", {62'b0, err}, 64'h0);
      wr(A_RDATA, 32'h1);
      wr(A_CTRL, 32'h0001_0009);
      wr(A_CMD, 32'h1);
      tick(4);
      chk("err_set", {62'b0, err}, 64'h1);
      wr(A_RDATA, 32'h2);
      wr(A_CMD, 32'h1);
      tick(4);
      chk("err_sticky", {62'b0, err}, 64'h1);
      wr(A_CMD, 32'h2);
      tick(2);
      chk("err_clr", {62'b0, err}, 64'h0);
`endif

      in_select = 2'b10;
      for (int k = 0; k < 24; k++) begin
         r_sel = 1'($urandom_range(0, 1));
         r_web = 1'($urandom_range(0, 1));
         r_a   = 8'($urandom_range(0, 15));
         r_d   = $urandom;
         wr(A_CTRL, {7'b0, r_sel, 7'b0, r_web, 8'b0, r_a});
         wr(A_WDATA, r_d);
         c0 = acc_cnt;
         wr(A_CMD, 32'h1);
         tick(4);
         chk("rnd_cnt", 64'(acc_cnt - c0), 64'd1);
         chk("rnd_acc", {m_csb, m_web, m_addr},
             {(r_sel ? 2'b01 : 2'b10), r_web, r_a});
         if (!r_web) begin
            chk("rnd_din", {32'b0, m_din}, {32'b0, r_d});
            ref_mem[r_sel][r_a] = r_d;
         end else begin
            rdw(A_RDATA, v);
            chk("rnd_rdata", {32'b0, v},
                {32'b0, ref_mem[r_sel][r_a]});
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
